// File: rtl/linear_regression_sample_source_pkg.sv
// -----------------------------------------------------------------------------
// lr_pkg
// Shared definitions for the linear-regression sample source:
//   - LR_DATA_WIDTH : default width of one x or z sample word
//   - lr_src_state_t: playback controller states
//   - lr_addr_width : RAM address width for a given depth
//   - lr_cnt_width  : width able to hold a count of 0..depth inclusive
// No ports (package).
// -----------------------------------------------------------------------------
package lr_pkg;

  localparam int LR_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    LR_SRC_IDLE   = 2'd0,
    LR_SRC_PRIME  = 2'd1,
    LR_SRC_STREAM = 2'd2,
    LR_SRC_DONE   = 2'd3
  } lr_src_state_t;

  // Address width for a RAM of 'depth' entries (at least one bit).
  function automatic int lr_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width must also represent the "full" value depth itself.
  function automatic int lr_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/linear_regression_sample_source_if.sv
// -----------------------------------------------------------------------------
// lr_src_if
// Load/command/stream bundle of the linear-regression sample source.
// Optional feature macro: LR_SRC_LOOP_EN (adds i_stop).
// Signals:
//   i_load_x/i_load_z/i_load_vld : pair to store at the next free slot
//   i_clear                      : empty the buffer
//   o_load_full                  : buffer holds RAM_DEPTH pairs
//   i_start                      : begin playback
//   i_stream_ready               : sink accepts the current pair
//   o_samples_{x,z}_{out,vld,last}: streamed pair with flags
//   o_data_samples_n             : stored pair count, zero-extended
//   o_busy/o_done                : playback status
//   i_stop (LR_SRC_LOOP_EN only) : end looping after the current pass
// Modports: slave = the sample source, master = its controller/sink.
// -----------------------------------------------------------------------------
interface lr_src_if
  import lr_pkg::*;
#(
  parameter int DATA_WIDTH = LR_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] i_load_x;
  logic [DATA_WIDTH-1:0] i_load_z;
  logic                  i_load_vld;
  logic                  i_clear;
  logic                  o_load_full;
  logic                  i_start;
  logic                  i_stream_ready;
  logic [DATA_WIDTH-1:0] o_samples_x_out;
  logic [DATA_WIDTH-1:0] o_samples_z_out;
  logic                  o_samples_x_vld;
  logic                  o_samples_z_vld;
  logic                  o_samples_x_last;
  logic                  o_samples_z_last;
  logic [DATA_WIDTH-1:0] o_data_samples_n;
  logic                  o_busy;
  logic                  o_done;
`ifdef LR_SRC_LOOP_EN
  logic                  i_stop;
`endif

  modport slave (
    input  i_load_x, i_load_z, i_load_vld, i_clear, i_start, i_stream_ready,
`ifdef LR_SRC_LOOP_EN
    input  i_stop,
`endif
    output o_load_full, o_samples_x_out, o_samples_z_out,
    output o_samples_x_vld, o_samples_z_vld, o_samples_x_last, o_samples_z_last,
    output o_data_samples_n, o_busy, o_done
  );

  modport master (
    output i_load_x, i_load_z, i_load_vld, i_clear, i_start, i_stream_ready,
`ifdef LR_SRC_LOOP_EN
    output i_stop,
`endif
    input  o_load_full, o_samples_x_out, o_samples_z_out,
    input  o_samples_x_vld, o_samples_z_vld, o_samples_x_last, o_samples_z_last,
    input  o_data_samples_n, o_busy, o_done
  );

endinterface

// File: rtl/linear_regression_sample_source_ram.sv
// -----------------------------------------------------------------------------
// lr_sample_ram
// Simple dual-port RAM holding packed {x, z} sample pairs.
// Ports:
//   i_clock   : clock
//   i_wr_en   : write enable
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_addr : read address, sampled every cycle
//   o_rd_data : read data, one cycle after the address
// The read is unconditional so the caller can "re-read" an address to keep
// the output stable; contents are not reset.
// -----------------------------------------------------------------------------
module lr_sample_ram #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 35,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clock,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/linear_regression_sample_source.sv
// -----------------------------------------------------------------------------
// linear_regression_sample_source
// Buffers up to RAM_DEPTH (x, z) pairs and replays them as a valid/ready
// stream with last flags and the sample count, feeding the estimator core.
// Optional feature macro: LR_SRC_LOOP_EN (repeat passes until i_stop).
// Ports:
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : lr_src_if.slave (load, command and stream signals)
// -----------------------------------------------------------------------------
module linear_regression_sample_source
  import lr_pkg::*;
#(
  parameter int DATA_WIDTH = LR_DATA_WIDTH,
  parameter int RAM_DEPTH  = 35
) (
  input  logic     i_clock,
  input  logic     i_reset,
  lr_src_if.slave  bus
);

  localparam int ADDR_WIDTH = lr_addr_width(RAM_DEPTH);
  localparam int CNT_WIDTH  = lr_cnt_width(RAM_DEPTH);

  lr_src_state_t           r_state;
  logic [CNT_WIDTH-1:0]    r_count;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;      // address whose data sits on the RAM output
  logic [DATA_WIDTH-1:0]   r_x;
  logic [DATA_WIDTH-1:0]   r_z;
  logic                    r_vld;
  logic                    r_last;
`ifdef LR_SRC_LOOP_EN
  logic                    r_stop_req;
`endif

  logic                    w_full;
  logic                    w_wr_en;
  logic                    w_accept;
  logic                    w_fill;
  logic                    w_finish;
  logic [ADDR_WIDTH-1:0]   w_last_addr;
  logic [ADDR_WIDTH-1:0]   w_rd_ptr_next;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic [2*DATA_WIDTH-1:0] w_rd_data;

  assign w_full      = (r_count == CNT_WIDTH'(RAM_DEPTH));
  assign w_wr_en     = (r_state == LR_SRC_IDLE) && bus.i_load_vld && !bus.i_clear && !w_full;
  assign w_last_addr = ADDR_WIDTH'(r_count - CNT_WIDTH'(1));
  // Wrapping at the final stored pair lets a loop pass restart with no bubble.
  assign w_rd_ptr_next = (r_rd_ptr == w_last_addr) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);
  assign w_accept    = r_vld && bus.i_stream_ready;
  // Output register takes new data when empty or when its pair is leaving.
  assign w_fill      = (r_state == LR_SRC_STREAM) && (!r_vld || bus.i_stream_ready);
`ifdef LR_SRC_LOOP_EN
  assign w_finish    = w_accept && r_last && (r_stop_req || bus.i_stop);
`else
  assign w_finish    = w_accept && r_last;
`endif
  // Holding the address while stalled keeps the RAM output on the pending pair.
  assign w_rd_addr   = (r_state == LR_SRC_PRIME) ? '0 :
                       (w_fill ? w_rd_ptr_next : r_rd_ptr);

  lr_sample_ram #(
    .WIDTH      (2 * DATA_WIDTH),
    .DEPTH      (RAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clock   (i_clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_count[ADDR_WIDTH-1:0]),
    .i_wr_data ({bus.i_load_x, bus.i_load_z}),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= LR_SRC_IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_x        <= '0;
      r_z        <= '0;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
`ifdef LR_SRC_LOOP_EN
      r_stop_req <= 1'b0;
`endif
    end else begin
      case (r_state)
        LR_SRC_IDLE: begin
`ifdef LR_SRC_LOOP_EN
          r_stop_req <= 1'b0;
`endif
          if (bus.i_clear) begin
            r_count <= '0;
          end else if (w_wr_en) begin
            r_count <= r_count + CNT_WIDTH'(1);
          end
          // A start coinciding with a clear sees an empty buffer.
          if (bus.i_start) begin
            if ((r_count != '0) && !bus.i_clear) begin
              r_state <= LR_SRC_PRIME;
            end else begin
              r_state <= LR_SRC_DONE;
            end
          end
        end

        LR_SRC_PRIME: begin
          r_rd_ptr <= '0;
          r_state  <= LR_SRC_STREAM;
        end

        LR_SRC_STREAM: begin
`ifdef LR_SRC_LOOP_EN
          if (bus.i_stop) begin
            r_stop_req <= 1'b1;
          end
`endif
          if (w_finish) begin
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_state <= LR_SRC_DONE;
          end else if (w_fill) begin
            {r_x, r_z} <= w_rd_data;
            r_vld      <= 1'b1;
            r_last     <= (r_rd_ptr == w_last_addr);
            r_rd_ptr   <= w_rd_ptr_next;
          end
        end

        LR_SRC_DONE: begin
          r_state <= LR_SRC_IDLE;
        end

        default: begin
          r_state <= LR_SRC_IDLE;
        end
      endcase
    end
  end

  assign bus.o_samples_x_out  = r_x;
  assign bus.o_samples_z_out  = r_z;
  assign bus.o_samples_x_vld  = r_vld;
  assign bus.o_samples_z_vld  = r_vld;
  assign bus.o_samples_x_last = r_last;
  assign bus.o_samples_z_last = r_last;
  assign bus.o_load_full      = w_full;
  assign bus.o_data_samples_n = DATA_WIDTH'(r_count);
  assign bus.o_busy           = (r_state != LR_SRC_IDLE);
  assign bus.o_done           = (r_state == LR_SRC_DONE);

endmodule

// File: tb/tb_linear_regression_sample_source.sv
// -----------------------------------------------------------------------------
// tb_linear_regression_sample_source
// Directed bench for linear_regression_sample_source. Inputs change 1 time
// unit after the rising edge; outputs are sampled at that same point.
// Optional feature macro: LR_SRC_LOOP_EN (adds the looping scenario).
// -----------------------------------------------------------------------------
module tb_linear_regression_sample_source;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lr_src_if #(.DATA_WIDTH(32)) bus ();

  linear_regression_sample_source #(
    .DATA_WIDTH (32),
    .RAM_DEPTH  (35)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int idx;
    int lasts;
    bit seen_done;

    bus.i_load_x       = '0;
    bus.i_load_z       = '0;
    bus.i_load_vld     = 1'b0;
    bus.i_clear        = 1'b0;
    bus.i_start        = 1'b0;
    bus.i_stream_ready = 1'b1;
`ifdef LR_SRC_LOOP_EN
    // Held high so single-pass scenarios end after one pass.
    bus.i_stop         = 1'b1;
`endif

    // ---------------- reset state ----------------
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_vld",  bus.o_samples_x_vld, 1'b0);
    chk("rst_done", bus.o_done, 1'b0);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_full", bus.o_load_full, 1'b0);
    chk("rst_n",    bus.o_data_samples_n, 0);

    // ---------------- load 35 pairs x=i, z=3i+7 ----------------
    for (int i = 0; i < 35; i++) begin
      bus.i_load_x   = i;
      bus.i_load_z   = 3 * i + 7;
      bus.i_load_vld = 1'b1;
      tick();
      $display("[TB] load %0d x=%0d z=%0d", i, 3 * i + 7 - 2 * i - 7, 3 * i + 7);
    end
    bus.i_load_vld = 1'b0;
    chk("load35_n",    bus.o_data_samples_n, 35);
    chk("load35_full", bus.o_load_full, 1'b1);

    // ---------------- full-rate playback ----------------
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("prime_busy", bus.o_busy, 1'b1);
    chk("prime_vld",  bus.o_samples_x_vld, 1'b0);
    tick();
    chk("stream_first_vld", bus.o_samples_x_vld, 1'b0);
    for (int i = 0; i < 35; i++) begin
      tick();
      $display("[TB] play %0d x=%0d z=%0d last=%0d", i, bus.o_samples_x_out,
               bus.o_samples_z_out, bus.o_samples_x_last);
      chk("play_xvld",  bus.o_samples_x_vld, 1'b1);
      chk("play_zvld",  bus.o_samples_z_vld, 1'b1);
      chk("play_x",     bus.o_samples_x_out, i);
      chk("play_z",     bus.o_samples_z_out, 3 * i + 7);
      chk("play_xlast", bus.o_samples_x_last, (i == 34));
      chk("play_zlast", bus.o_samples_z_last, (i == 34));
      chk("play_n",     bus.o_data_samples_n, 35);
    end
    tick();
    chk("play_done",     bus.o_done, 1'b1);
    chk("play_done_vld", bus.o_samples_x_vld, 1'b0);
    tick();
    chk("play_done_end", bus.o_done, 1'b0);
    chk("play_idle",     bus.o_busy, 1'b0);

    // ---------------- stalled playback, ready = 1,0,0,1,... ----------------
    idx       = 0;
    lasts     = 0;
    seen_done = 1'b0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      bus.i_stream_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (bus.o_done) begin
        seen_done = 1'b1;
      end else if (bus.o_samples_x_vld) begin
        chk("stall_x",    bus.o_samples_x_out, idx);
        chk("stall_z",    bus.o_samples_z_out, 3 * idx + 7);
        chk("stall_last", bus.o_samples_x_last, (idx == 34));
        if (bus.i_stream_ready) begin
          $display("[TB] stall accept %0d x=%0d", idx, bus.o_samples_x_out);
          if (bus.o_samples_x_last) lasts++;
          idx++;
        end
      end
      if (!seen_done) tick();
    end
    chk("stall_done_seen", seen_done, 1'b1);
    chk("stall_count",     idx, 35);
    chk("stall_lasts",     lasts, 1);
    bus.i_stream_ready = 1'b1;
    tick();

    // ---------------- reset mid-stream at pair 10 ----------------
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    for (int i = 0; i <= 10; i++) tick();
    chk("mid_pair10_x", bus.o_samples_x_out, 10);
    #1;
    rst = 1'b1;
    #1;
    $display("[TB] async reset at pair 10");
    chk("arst_vld",  bus.o_samples_x_vld, 1'b0);
    chk("arst_x",    bus.o_samples_x_out, 0);
    chk("arst_z",    bus.o_samples_z_out, 0);
    chk("arst_busy", bus.o_busy, 1'b0);
    chk("arst_n",    bus.o_data_samples_n, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_n", bus.o_data_samples_n, 0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    $display("[TB] start on empty buffer after reset");
    chk("empty_done", bus.o_done, 1'b1);
    chk("empty_vld",  bus.o_samples_x_vld, 1'b0);
    tick();
    chk("empty_done_end", bus.o_done, 1'b0);
    chk("empty_vld2",     bus.o_samples_x_vld, 1'b0);

    // ---------------- fill to saturation, 36th ignored ----------------
    for (int i = 0; i < 36; i++) begin
      bus.i_load_x   = (i == 35) ? 999 : i;
      bus.i_load_z   = 3 * i + 7;
      bus.i_load_vld = 1'b1;
      tick();
      $display("[TB] fill %0d n=%0d full=%0d", i, bus.o_data_samples_n, bus.o_load_full);
      if (i == 33) chk("fill34_full", bus.o_load_full, 1'b0);
      if (i == 34) begin
        chk("fill35_full", bus.o_load_full, 1'b1);
        chk("fill35_n",    bus.o_data_samples_n, 35);
      end
      if (i == 35) begin
        chk("fill36_full", bus.o_load_full, 1'b1);
        chk("fill36_n",    bus.o_data_samples_n, 35);
      end
    end

    // ---------------- clear has priority over load ----------------
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear    = 1'b0;
    bus.i_load_vld = 1'b0;
    $display("[TB] clear with simultaneous load");
    chk("clear_n",    bus.o_data_samples_n, 0);
    chk("clear_full", bus.o_load_full, 1'b0);

    // ---------------- 4 pairs, loads/clears ignored while streaming ----------
    for (int i = 0; i < 4; i++) begin
      bus.i_load_x   = 100 + i;
      bus.i_load_z   = 200 + i;
      bus.i_load_vld = 1'b1;
      tick();
    end
    bus.i_load_vld = 1'b0;
    chk("load4_n", bus.o_data_samples_n, 4);
    bus.i_start = 1'b1;
    tick();
    bus.i_start    = 1'b0;
    bus.i_load_vld = 1'b1;
    bus.i_clear    = 1'b1;
    bus.i_load_x   = 555;
    bus.i_load_z   = 666;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("[TB] busy-load play %0d x=%0d z=%0d", i, bus.o_samples_x_out, bus.o_samples_z_out);
      chk("ign_vld",  bus.o_samples_x_vld, 1'b1);
      chk("ign_x",    bus.o_samples_x_out, 100 + i);
      chk("ign_z",    bus.o_samples_z_out, 200 + i);
      chk("ign_last", bus.o_samples_x_last, (i == 3));
      chk("ign_n",    bus.o_data_samples_n, 4);
    end
    bus.i_load_vld = 1'b0;
    bus.i_clear    = 1'b0;
    tick();
    chk("ign_done", bus.o_done, 1'b1);
    chk("ign_n_end", bus.o_data_samples_n, 4);
    tick();

`ifdef LR_SRC_LOOP_EN
    // ---------------- looping: stop raised during pass 3 ----------------
    bus.i_stop  = 1'b0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    for (int j = 0; j < 12; j++) begin
      tick();
      $display("[TB] loop pair %0d x=%0d last=%0d", j + 1, bus.o_samples_x_out, bus.o_samples_x_last);
      chk("loop_vld",  bus.o_samples_x_vld, 1'b1);
      chk("loop_x",    bus.o_samples_x_out, 100 + (j % 4));
      chk("loop_last", bus.o_samples_x_last, ((j % 4) == 3));
      chk("loop_done", bus.o_done, 1'b0);
      if (j == 9) bus.i_stop = 1'b1;
    end
    tick();
    chk("loop_end_done", bus.o_done, 1'b1);
    chk("loop_end_vld",  bus.o_samples_x_vld, 1'b0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/linear_regression_sample_source.md
# linear_regression_sample_source

Sample-stream transmitter that feeds the `linear_regression_estimation` core. It buffers up to `RAM_DEPTH` (x, z) sample pairs written through a load port. On command it replays them as paired x/z streams with valid/last flags and the sample count `N`, matching the core's sample input interface. It is the hardware replacement for the bench-side file loader that drives the estimator.

## Interface
- `DATA_WIDTH`, 32, width of each x and z sample word
- `RAM_DEPTH`, 35, maximum number of stored sample pairs; `ADDR_WIDTH = $clog2(RAM_DEPTH)`
- `i_clock`  in  1  sole clock, rising edge
- `i_reset`  in  1  reset, asynchronous, active-high
- `i_load_x`  in  DATA_WIDTH  x sample to store
- `i_load_z`  in  DATA_WIDTH  z sample to store
- `i_load_vld`  in  1  write the (x, z) pair at the next free slot
- `i_clear`  in  1  empty the buffer (count := 0)
- `o_load_full`  out  1  count == RAM_DEPTH
- `i_start`  in  1  begin playback of the stored pairs
- `i_stream_ready`  in  1  sink accepts the current pair; tie to 1 for the estimator
- `o_samples_x_out`, `o_samples_z_out`  out  DATA_WIDTH  current pair
- `o_samples_x_vld`, `o_samples_z_vld`  out  1  identical; pair valid
- `o_samples_x_last`, `o_samples_z_last`  out  1  identical; asserted with final pair
- `o_data_samples_n`  out  DATA_WIDTH  stored count, zero-extended; stable during playback
- `o_busy`  out  1  playback in progress
- `o_done`  out  1  one-cycle pulse after last pair accepted

## Operation
- States: IDLE, PRIME, STREAM, DONE.
- IDLE:
  - `i_load_vld` writes RAM[count] and increments count. Ignored when full; count saturates at RAM_DEPTH.
  - `i_clear` sets count to 0 and has priority over `i_load_vld` in the same cycle.
  - `i_start` with count > 0 goes to PRIME. `i_start` with count == 0 goes directly to DONE (pulses `o_done`, no valid).
- PRIME: issue read of address 0; next state STREAM.
- STREAM:
  - The output register loads the RAM read data when empty or when the current pair is accepted (`vld && i_stream_ready`). The next read address is issued in the same cycle.
  - `last` is set on the pair read from address count-1.
  - Acceptance of the last pair goes to DONE.
- DONE: `o_done` = 1 for one cycle, then IDLE.
- Outside IDLE, `i_load_vld`, `i_clear` and `i_start` are ignored.
- Stall: while `vld && !i_stream_ready`, data, vld and last hold unchanged and the read address does not advance.
- `o_busy` = 1 in PRIME, STREAM and DONE.
- Reset (any time, including mid-stream):
  - state IDLE, count 0.
  - all outputs 0; `o_load_full` 0.
  - RAM contents need not be cleared.

## Timing
- `i_start` sampled at edge k: PRIME during cycle k..k+1; first pair valid after edge k+2.
- With `i_stream_ready` = 1: N pairs on N consecutive cycles, no bubbles; `last` on the N-th.
- `o_done` is high the cycle after the last acceptance. A new `i_start` is accepted no earlier than 2 cycles after last acceptance.
- `o_load_full` updates the cycle after the write that fills the buffer.
- `o_data_samples_n` updates the cycle after each load or clear.

## Configuration
- `LR_SRC_LOOP_EN` defined:
  - adds input `i_stop`.
  - after the last pair is accepted, playback restarts at address 0 with no bubble and no DONE. `last` is still flagged on each pass's final pair.
  - `i_stop` sampled in STREAM goes to DONE after the current pass's last pair is accepted.
- Not defined: single pass only, no `i_stop` port.

## Structure
- Shared package `lr_pkg`: `DATA_WIDTH` default, the state enum (`LR_SRC_IDLE`, `LR_SRC_PRIME`, `LR_SRC_STREAM`, `LR_SRC_DONE`), and the addr/count width function.
- One sub-module `lr_sample_ram`: simple dual-port RAM, 2*DATA_WIDTH wide, RAM_DEPTH deep, synchronous read with 1-cycle latency, write-first not required.

## Test plan
- Load 35 pairs (x=i, z=3i+7), start, ready=1:
  - valid on 35 consecutive cycles beginning 2 cycles after start.
  - values match; last only on pair 34 (x=34, z=109).
  - `o_data_samples_n`=35; `o_done` pulse one cycle later.
- Same load; ready toggles 1,0,0,1 repeating:
  - each pair held through stall cycles; no pair skipped or duplicated.
  - last accepted exactly once.
- Empty buffer:
  - `i_start` → `o_done` pulse after 1 cycle, vld never asserted.
  - load 36 pairs → `o_load_full`=1 after the 35th; 36th ignored; count 35.
- Reset asserted mid-stream at pair 10:
  - all outputs 0 immediately (async).
  - after release, `o_data_samples_n`=0; start yields DONE with no valid.
- Load 4 pairs, start; pulse `i_load_vld` and `i_clear` during STREAM → both ignored; 4 pairs streamed; count remains 4.
- With `LR_SRC_LOOP_EN`, 4 pairs, `i_stop` raised during pass 3:
  - 12 back-to-back pairs; last on pairs 4, 8 and 12.
  - `o_done` after pair 12.
